baud_rate_gen: RTL

BAUD_RATE_GEN -- requirements
Module: baud_rate_gen

---
 rtl/baud_pkg.sv | 45 ++++
 rtl/os_divider.sv | 38 +++
 rtl/baud_rate_gen.sv | 88 ++++++++
 3 files changed

// File: rtl/baud_pkg.sv
// Shared definitions for the baud rate generator: rate indices, the baud table
// and the phase-increment computation used to build the per-rate constants.
package baud_pkg;

    typedef enum logic [2:0] {
        RATE_9600   = 3'd0,
        RATE_19200  = 3'd1,
        RATE_38400  = 3'd2,
        RATE_57600  = 3'd3,
        RATE_115200 = 3'd4,
        RATE_230400 = 3'd5,
        RATE_460800 = 3'd6,
        RATE_921600 = 3'd7
    } rate_e;

    function automatic longint unsigned baud_of(input logic [2:0] idx);
        longint unsigned baud;
        case (idx)
            3'd0:    baud = 64'd9600;
            3'd1:    baud = 64'd19200;
            3'd2:    baud = 64'd38400;
            3'd3:    baud = 64'd57600;
            3'd4:    baud = 64'd115200;
            3'd5:    baud = 64'd230400;
            3'd6:    baud = 64'd460800;
            3'd7:    baud = 64'd921600;
            default: baud = 64'd9600;
        endcase
        return baud;
    endfunction

    // Round-to-nearest of OVERSAMPLE*BAUD*2^ACC_W/CLK_FREQ; only ever
    // evaluated at elaboration time to build constants.
    function automatic longint unsigned calc_inc(
        input longint unsigned clk_freq,
        input longint unsigned oversample,
        input int unsigned     acc_w,
        input logic [2:0]      idx
    );
        longint unsigned num;
        num = (oversample * baud_of(idx)) << acc_w;
        return (num + (clk_freq >> 1)) / clk_freq;
    endfunction

endpackage

// File: rtl/os_divider.sv
// Counts oversample carries and flags the one that completes a bit period.
module os_divider
    import baud_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic carry,
    output logic bit_tick
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] os_cnt_r;
    logic             bit_tick_r;

    // Oversample counter and registered bit tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            os_cnt_r   <= '0;
            bit_tick_r <= 1'b0;
        end else if (clear) begin
            os_cnt_r   <= '0;
            bit_tick_r <= 1'b0;
        end else if (carry) begin
            bit_tick_r <= (os_cnt_r == LAST);
            os_cnt_r   <= (os_cnt_r == LAST) ? '0 : os_cnt_r + CNT_W'(1);
        end else begin
            bit_tick_r <= 1'b0;
        end
    end

    assign bit_tick = bit_tick_r;

endmodule

// File: rtl/baud_rate_gen.sv
// Fractional phase-accumulator baud generator producing oversample and bit
// ticks for a UART, with run enable, rate select and start-bit realignment.
module baud_rate_gen
    import baud_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned ACC_W      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] baud_sel,
    input  logic       restart,
    output logic       os_tick,
    output logic       bit_tick,
    output logic [2:0] rate_idx
);

    localparam logic [ACC_W-1:0] HALF_PHASE = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0] inc_table_s [8];

    for (genvar g = 0; g < 8; g++) begin : g_inc
        localparam logic [ACC_W-1:0] INC =
            ACC_W'(calc_inc(64'(CLK_FREQ), 64'(OVERSAMPLE), ACC_W, 3'(g)));
        assign inc_table_s[g] = INC;
    end

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] inc_r;
    rate_e            rate_r;
    logic             os_tick_r;

    logic [ACC_W:0]   sum_s;
    logic             realign_s;
    logic             reload_s;
    logic             advance_s;
    logic             carry_s;
    logic             os_clear_s;

    // Restart outranks a rate change; the accumulator only advances when neither is pending.
    always_comb begin
        sum_s      = {1'b0, acc_r} + {1'b0, inc_r};
        realign_s  = en & restart;
        reload_s   = en & ~restart & (baud_sel != rate_r);
        advance_s  = en & ~restart & (baud_sel == rate_r);
        carry_s    = advance_s & sum_s[ACC_W];
        os_clear_s = realign_s | reload_s;
    end

    // Phase accumulator, active rate and registered oversample tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r     <= '0;
            inc_r     <= inc_table_s[0];
            rate_r    <= RATE_9600;
            os_tick_r <= 1'b0;
        end else if (realign_s) begin
            acc_r     <= HALF_PHASE;
            os_tick_r <= 1'b0;
        end else if (reload_s) begin
            acc_r     <= '0;
            inc_r     <= inc_table_s[baud_sel];
            rate_r    <= rate_e'(baud_sel);
            os_tick_r <= 1'b0;
        end else if (advance_s) begin
            acc_r     <= sum_s[ACC_W-1:0];
            os_tick_r <= sum_s[ACC_W];
        end else begin
            os_tick_r <= 1'b0;
        end
    end

    os_divider #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_os_divider (
        .clk      (clk),
        .rst      (rst),
        .clear    (os_clear_s),
        .carry    (carry_s),
        .bit_tick (bit_tick)
    );

    assign os_tick  = os_tick_r;
    assign rate_idx = rate_r;

endmodule
